// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory request/acknowledge bus between the fetch
//            stage (master) and the instruction memory (slave).
// Signals  : imem_req   - read request, held until imem_ack
//            imem_addr  - word address of the request
//            imem_ack   - response valid for the outstanding request
//            imem_rdata - instruction word, valid with imem_ack
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Issues sequential word fetches over a
//            single-outstanding req/ack memory bus, buffers returned words in
//            an output register plus one skid register so decode stalls never
//            drop an instruction, and restarts on a redirect from execute.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            stall               - decode cannot accept the presented insn
//            redirect/redirect_pc- flush and restart fetch at redirect_pc
//            mem (master)        - instruction memory bus (fetch_unit_if)
//            insn/pc/valid_insn  - instruction stream to decode
//            fetch_misalign      - sticky misaligned-target flag
//                                  (only with FETCH_ALIGN_CHECK_EN)
// Config   : `define FETCH_ALIGN_CHECK_EN adds misaligned-redirect detection
//            and a HALT state; otherwise redirect targets are word-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master mem,
  output logic [31:0]  insn,
  output logic [31:0]  pc,
  output logic         valid_insn
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic         fetch_misalign
`endif
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FULL = 2'd1,
    ST_HALT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FULL = 2'd1
  } state_t;
`endif

  state_t      r_state;
  logic        r_req;        // request on the bus, waiting for its ack
  logic        r_squash;     // flushed request still in flight; ack is dropped
  logic [31:0] r_fpc;        // address of the current / next request
  logic        r_out_v;
  logic [31:0] r_out_insn;
  logic [31:0] r_out_pc;
  logic        r_skid_v;
  logic [31:0] r_skid_insn;
  logic [31:0] r_skid_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_misalign;
  logic        w_misalign;
`endif

  logic        w_take;
  logic        w_consume;
  logic        w_skid_fill;
  logic        w_skid_empty_next;
  logic        w_out_v_next;
  logic [31:0] w_target;

  // An ack only counts for a live (non-squashed) request.
  assign w_take            = mem.imem_ack & r_req;
  assign w_consume         = r_out_v & ~stall;
  // A returning word lands in skid only when the output is held by a stall.
  assign w_skid_fill       = w_take & r_out_v & stall;
  assign w_skid_empty_next = ~w_skid_fill & (~r_skid_v | w_consume);
  assign w_out_v_next      = w_take | (w_consume ? r_skid_v : r_out_v);
  assign w_target          = redirect_pc & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misalign        = |redirect_pc[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_req       <= 1'b0;
      r_squash    <= 1'b0;
      r_fpc       <= RESET_PC;
      r_out_v     <= 1'b0;
      r_out_insn  <= 32'h0;
      r_out_pc    <= 32'h0;
      r_skid_v    <= 1'b0;
      r_skid_insn <= 32'h0;
      r_skid_pc   <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_misalign  <= 1'b0;
`endif
    end else if (redirect) begin
      // Flush wins over stall and over a same-cycle ack.
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_fpc    <= w_target;
`ifdef FETCH_ALIGN_CHECK_EN
      if (w_misalign || (r_state == ST_HALT)) begin
        r_state  <= ST_HALT;
        r_req    <= 1'b0;
        r_squash <= 1'b0;
        if (w_misalign) begin
          r_misalign <= 1'b1;
        end
      end else
`endif
      begin
        r_state <= ST_RUN;
        if ((r_req || r_squash) && !mem.imem_ack) begin
          // Still in flight: wait for its ack before issuing the new target.
          r_req    <= 1'b0;
          r_squash <= 1'b1;
        end else begin
          r_req    <= 1'b1;
          r_squash <= 1'b0;
        end
      end
    end else begin
      case (r_state)
`ifdef FETCH_ALIGN_CHECK_EN
        ST_HALT: begin
          r_req    <= 1'b0;
          r_squash <= 1'b0;
          r_out_v  <= 1'b0;
          r_skid_v <= 1'b0;
        end
`endif
        default: begin
          if (w_take) begin
            r_fpc <= r_fpc + 32'd4;
            if (w_skid_fill) begin
              r_skid_v    <= 1'b1;
              r_skid_insn <= mem.imem_rdata;
              r_skid_pc   <= r_fpc;
            end else begin
              r_out_v    <= 1'b1;
              r_out_insn <= mem.imem_rdata;
              r_out_pc   <= r_fpc;
            end
          end else if (w_consume) begin
            r_out_v <= r_skid_v;
            if (r_skid_v) begin
              r_out_insn <= r_skid_insn;
              r_out_pc   <= r_skid_pc;
            end
            r_skid_v <= 1'b0;
          end

          // Next request goes out in the ack cycle whenever the skid will be
          // free, giving one instruction per cycle with a 1-cycle memory.
          if (r_squash) begin
            if (mem.imem_ack) begin
              r_squash <= 1'b0;
              r_req    <= w_skid_empty_next;
            end
          end else if (!r_req || mem.imem_ack) begin
            r_req <= w_skid_empty_next;
          end

          r_state <= (w_out_v_next && !w_skid_empty_next) ? ST_FULL : ST_RUN;
        end
      endcase
    end
  end

  assign mem.imem_req  = r_req;
  assign mem.imem_addr = r_fpc;
  assign insn          = r_out_insn;
  assign pc            = r_out_pc;
  assign valid_insn    = r_out_v;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_misalign = r_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A memory model answers
//            requests with a random or fixed latency; a scoreboard queue holds
//            the expected pc stream and a monitor pops it on every accepted
//            instruction. Directed sequences cover reset, stall/skid,
//            squashed redirects, address wrap and reset during a request.
// Config   : honours `define FETCH_ALIGN_CHECK_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  localparam logic [31:0] C_RESET_PC = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        valid_insn;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem         (bus),
    .insn        (insn),
    .pc          (pc),
    .valid_insn  (valid_insn)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          pops = 0;
  int          lat_fixed = 1;   // 0 selects a random latency of 1..4
  logic [31:0] exp_q[$];

  // Memory contents: address 0 holds an all-zero word.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0 : ({a[15:0], a[31:16]} ^ 32'hC0DE_1234);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream after a (re)start: consecutive words, wrapping at 2^32.
  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 2048; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
`ifdef FETCH_ALIGN_CHECK_EN
    if (tgt[1:0] != 2'b00) exp_q.delete();
    else sb_restart(tgt);
`else
    sb_restart(tgt & ~32'h3);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req), 32'h0);
    chk({tag, "_addr"},  bus.imem_addr,     C_RESET_PC);
    chk({tag, "_insn"},  insn,              32'h0);
    chk({tag, "_pc"},    pc,                32'h0);
    chk({tag, "_valid"}, 32'(valid_insn),   32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, "_mis"},   32'(fetch_misalign), 32'h0);
`endif
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release and check
  // that the first request goes out on the first edge after release.
  task automatic do_reset(input string tag);
    stall    = 1'b0;
    redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset({tag, "_async"});
    step();
    step();
    chk_reset({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
    sb_restart(C_RESET_PC);
    step();
    chk({tag, "_req1"},  32'(bus.imem_req), 32'h1);
    chk({tag, "_addr1"}, bus.imem_addr,     C_RESET_PC);
  endtask

  // ------------------------------------------------------------------ memory
  logic        mbusy;
  int          mrem;
  logic [31:0] maddr;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy          = 1'b0;
      mrem           = 0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
    end else begin
      if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
        mbusy        = 1'b0;
      end
      if (mbusy && bus.imem_req) chk("req_hold_addr", bus.imem_addr, maddr);
      if (!mbusy && bus.imem_req) begin
        mbusy = 1'b1;
        maddr = bus.imem_addr;
        mrem  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      end
      if (mbusy) begin
        mrem--;
        if (mrem == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = memf(maddr);
        end
      end
    end
  end

  // ----------------------------------------------------------------- monitor
  logic        hold_chk = 1'b0;
  logic        prev_redirect = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_insn;
  logic [31:0] mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_chk) begin
        chk("stall_hold_valid", 32'(valid_insn), 32'h1);
        chk("stall_hold_pc",    pc,              hold_pc);
        chk("stall_hold_insn",  insn,            hold_insn);
      end
      if (prev_redirect) chk("flush_valid", 32'(valid_insn), 32'h0);
      if (valid_insn && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pc", pc, 32'hDEAD_DEAD);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_pc",   pc,   mon_e);
          chk("sb_insn", insn, memf(mon_e));
          pops++;
        end
      end
      hold_chk      = valid_insn && stall && !redirect;
      hold_pc       = pc;
      hold_insn     = insn;
      prev_redirect = redirect;
    end else begin
      hold_chk      = 1'b0;
      prev_redirect = 1'b0;
    end
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] tgt;
    int          p0;
    int          len;

    // Reset release with a 1-cycle memory: back-to-back fetch.
    lat_fixed = 1;
    do_reset("rst");
    step();
    chk("seq_addr2", bus.imem_addr, 32'h8002_0004);
    chk("seq_valid2", 32'(valid_insn), 32'h1);
    chk("seq_pc2", pc, 32'h8002_0000);
    chk("seq_insn2", insn, memf(32'h8002_0000));
    step();
    chk("seq_addr3", bus.imem_addr, 32'h8002_0008);
    chk("seq_pc3", pc, 32'h8002_0004);

    // Stall for 4 cycles on 80020004: 80020008 parks in the skid.
    stall = 1'b1;
    repeat (4) begin
      step();
      chk("stall_pc", pc, 32'h8002_0004);
      chk("stall_insn", insn, memf(32'h8002_0004));
      chk("stall_req", 32'(bus.imem_req), 32'h0);
    end
    stall     = 1'b0;
    lat_fixed = 3;
    step();
    chk("skid_pc", pc, 32'h8002_0008);
    chk("skid_req", 32'(bus.imem_req), 32'h1);
    chk("skid_addr", bus.imem_addr, 32'h8002_000C);

    // Redirect while 8002000C waits on a 3-cycle ack: it is squashed.
    step();
    lat_fixed = 1;
    redir(32'h8002_0100);
    step();
    redirect = 1'b0;
    chk("squash_req", 32'(bus.imem_req), 32'h0);
    chk("squash_valid", 32'(valid_insn), 32'h0);
    step();
    chk("squash_newreq", 32'(bus.imem_req), 32'h1);
    chk("squash_newaddr", bus.imem_addr, 32'h8002_0100);
    step();
    chk("squash_pc", pc, 32'h8002_0100);
    chk("squash_vld", 32'(valid_insn), 32'h1);

    // Redirect to the top word, coinciding with an ack: address wraps to 0.
    redir(32'hFFFF_FFFC);
    step();
    redirect = 1'b0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc_zero", pc, 32'h0);
    chk("wrap_insn_zero", insn, 32'h0);
    chk("wrap_valid_zero", 32'(valid_insn), 32'h1);

    // Misaligned target.
    redir(32'h8002_0102);
    step();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    repeat (5) begin
      chk("halt_mis", 32'(fetch_misalign), 32'h1);
      chk("halt_req", 32'(bus.imem_req), 32'h0);
      chk("halt_valid", 32'(valid_insn), 32'h0);
      step();
    end
    do_reset("halt_rst");
`else
    chk("align_addr", bus.imem_addr, 32'h8002_0100);
    step();
    chk("align_pc", pc, 32'h8002_0100);
`endif

    // Reset asserted while a slow request is outstanding.
    repeat (4) step();
    lat_fixed = 4;
    repeat (3) step();
    chk("midreq_pending", 32'(bus.imem_req), 32'h1);
    do_reset("midreq");

    // Randomised traffic: random latency, stalls and redirects.
    lat_fixed = 0;
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(5, 30);
      repeat (len) begin
        stall = ($urandom_range(0, 9) < 3);
        step();
      end
      p0 = pops;
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 2))
          0:       tgt = $urandom;
          1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
          default: tgt = C_RESET_PC + ($urandom & 32'h0000_0FFC);
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        tgt = tgt & ~32'h3;
`endif
        redir(tgt);
        step();
        redirect = 1'b0;
      end
      stall = 1'b0;
      repeat (14) step();
      chk("progress", 32'(pops > p0), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
